// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Defaults describe the 64-bit, 32-entry, two-read-port core configuration with XZR at index 31.
package regfile_pkg;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_ZERO_REG = 31;
    localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

    // Number of set bits in a default-sized busy vector.
    function automatic int popcount(input logic [DEF_NUM_REGS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < DEF_NUM_REGS; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits plus a running count of busy registers.
// The enables arrive already qualified: the caller has removed the zero register and out-of-range
// addresses. A set and a clear that hit the same register in the same cycle leave it busy,
// because the newly issued producer is the one that still has to write back.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS = DEF_NUM_REGS,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en,
    input  logic [ADDR_W-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    output logic [NUM_REGS-1:0] busy,
    output logic [ADDR_W:0]     busy_cnt
);

    localparam int CNT_W = ADDR_W + 1;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                cnt_inc;
    logic                cnt_dec;

    // Next busy vector: clear first, then set, so a same-register collision ends busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    // Counter tracks real 0->1 and 1->0 transitions only, keeping it equal to the popcount.
    always_comb begin
        cnt_inc = set_en && !busy_q[set_addr];
        cnt_dec = clr_en && busy_q[clr_addr] && !(set_en && (set_addr == clr_addr));
        cnt_d   = cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end

    // Scoreboard state; reset discards every pending issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with hardwired-zero register, NUM_RD combinational read ports, one write port
// and a per-register busy scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN -- same-cycle forwarding of the write port to reads.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int NUM_RD   = DEF_NUM_RD,
    parameter  int ZERO_REG = DEF_ZERO_REG,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam logic [ADDR_W-1:0] ZERO_A     = ZERO_REG[ADDR_W-1:0];
    localparam bit                FULL_RANGE = (NUM_REGS == (1 << ADDR_W));

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wr_in_range;
    logic                iss_in_range;
    logic [NUM_RD-1:0]   rd_in_range;
    logic                wr_ok;
    logic                iss_ok;

    // Range checks only exist when the address width can encode indices past the last register.
    generate
        if (FULL_RANGE) begin : g_full_range
            assign wr_in_range  = 1'b1;
            assign iss_in_range = 1'b1;
            assign rd_in_range  = '1;
        end else begin : g_part_range
            localparam logic [ADDR_W-1:0] LIMIT_A = NUM_REGS[ADDR_W-1:0];
            assign wr_in_range  = (wr_addr < LIMIT_A);
            assign iss_in_range = (iss_addr < LIMIT_A);
            for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_range
                assign rd_in_range[gi] = (rd_addr[gi*ADDR_W +: ADDR_W] < LIMIT_A);
            end
        end
    endgenerate

    assign wr_ok  = wr_en && wr_in_range && (wr_addr != ZERO_A);
    assign iss_ok = iss_en && iss_in_range && (iss_addr != ZERO_A);

    // Write decode into the storage array.
    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Storage array; every register clears on reset so reads return 0 during reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (iss_ok),
        .set_addr (iss_addr),
        .clr_en   (wr_ok),
        .clr_addr (wr_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    // One independent read mux per port.
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              valid;
            logic [DATA_W-1:0] data_p;
            logic              busy_p;

            assign addr  = rd_addr[gi*ADDR_W +: ADDR_W];
            assign valid = rd_in_range[gi] && (addr != ZERO_A);

`ifdef REGFILE_BYPASS_EN
            logic hit;
            assign hit = wr_ok && (wr_addr == addr);

            // Forward the writeback value; busy drops unless a new producer claims it this cycle.
            always_comb begin
                data_p = '0;
                busy_p = 1'b0;
                if (valid) begin
                    if (hit) begin
                        data_p = wr_data;
                        busy_p = (iss_en && (iss_addr == addr)) ? busy[addr] : 1'b0;
                    end else begin
                        data_p = mem_q[addr];
                        busy_p = busy[addr];
                    end
                end
            end
`else
            // Stored state only; a write becomes visible on the following cycle.
            always_comb begin
                data_p = '0;
                busy_p = 1'b0;
                if (valid) begin
                    data_p = mem_q[addr];
                    busy_p = busy[addr];
                end
            end
`endif

            assign rd_data[gi*DATA_W +: DATA_W] = data_p;
            assign rd_busy[gi]                  = busy_p;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb in its default configuration (64 x 32, two read ports, XZR = 31).
module tb_regfile_sb;
    import regfile_pkg::*;

    logic         clk;
    logic         reset;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         iss_en;
    logic [4:0]   iss_addr;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data;
    logic [1:0]   rd_busy;
    logic [5:0]   busy_cnt;

    int total;
    int bad;

    regfile_sb #(
        .DATA_W   (64),
        .NUM_REGS (32),
        .NUM_RD   (2),
        .ZERO_REG (31)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr[4:0] = a0[4:0];
        rd_addr[9:5] = a1[4:0];
    endtask

    // One clocked transaction: drive, print, clock, release, settle.
    task automatic txn(input logic we, input int wa, input logic [63:0] wd,
                       input logic ie, input int ia);
        wr_en    = we;
        wr_addr  = wa[4:0];
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = ia[4:0];
        $display("txn wr_en=%0d wr_addr=%0d wr_data=%h iss_en=%0d iss_addr=%0d",
                 we, wa, wd, ie, ia);
        cyc();
        wr_en  = 1'b0;
        iss_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_rd(5, 6);
        repeat (2) cyc();
        total++;
        if (busy_cnt !== 6'd0) begin
            bad++; $display("FAIL reset_cnt got=%0d exp=0", busy_cnt);
        end
        total++;
        if (rd_data[63:0] !== 64'd0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", rd_data[63:0]);
        end
        #2 reset = 1'b1;
        cyc();
        txn(1'b1, 5, 64'hDEAD, 1'b1, 6);
        total++;
        if (rd_data[63:0] !== 64'hDEAD) begin
            bad++; $display("FAIL pre_reset_data got=%h exp=dead", rd_data[63:0]);
        end
        total++;
        if (rd_busy[1] !== 1'b1 || busy_cnt !== 6'd1) begin
            bad++; $display("FAIL pre_reset_busy got busy=%b cnt=%0d exp busy=1 cnt=1", rd_busy[1], busy_cnt);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (rd_data[63:0] !== 64'd0) begin
            bad++; $display("FAIL async_reset_data got=%h exp=0", rd_data[63:0]);
        end
        total++;
        if (busy_cnt !== 6'd0 || rd_busy !== 2'b00) begin
            bad++; $display("FAIL async_reset_busy got cnt=%0d busy=%b exp cnt=0 busy=00", busy_cnt, rd_busy);
        end
        #2 reset = 1'b1;
        cyc();
    endtask

    task automatic test_write_read_all();
        logic [63:0] e0;
        logic [63:0] e1;
        int          p1;
        for (int i = 0; i < 31; i++) begin
            txn(1'b1, i, 64'h1000 + 64'(i), 1'b0, 0);
        end
        for (int i = 0; i < 32; i++) begin
            p1 = (i + 7) % 32;
            set_rd(i, p1);
            #1;
            e0 = (i == 31) ? 64'd0 : 64'h1000 + 64'(i);
            e1 = (p1 == 31) ? 64'd0 : 64'h1000 + 64'(p1);
            total++;
            if (rd_data[63:0] !== e0) begin
                bad++; $display("FAIL read_p0 r%0d got=%h exp=%h", i, rd_data[63:0], e0);
            end
            total++;
            if (rd_data[127:64] !== e1) begin
                bad++; $display("FAIL read_p1 r%0d got=%h exp=%h", p1, rd_data[127:64], e1);
            end
        end
        txn(1'b1, 31, 64'hFFFF, 1'b0, 0);
        set_rd(31, 31);
        #1;
        total++;
        if (rd_data !== 128'd0) begin
            bad++; $display("FAIL zero_reg_write got=%h exp=0", rd_data);
        end
    endtask

    task automatic test_scoreboard();
        set_rd(3, 4);
        txn(1'b0, 0, 64'd0, 1'b1, 3);
        total++;
        if (busy_cnt !== 6'd1 || rd_busy !== 2'b01) begin
            bad++; $display("FAIL issue_r3 got cnt=%0d busy=%b exp cnt=1 busy=01", busy_cnt, rd_busy);
        end
        txn(1'b0, 0, 64'd0, 1'b1, 4);
        total++;
        if (busy_cnt !== 6'd2 || rd_busy !== 2'b11) begin
            bad++; $display("FAIL issue_r4 got cnt=%0d busy=%b exp cnt=2 busy=11", busy_cnt, rd_busy);
        end
        set_rd(31, 4);
        txn(1'b0, 0, 64'd0, 1'b1, 31);
        total++;
        if (busy_cnt !== 6'd2 || rd_busy !== 2'b10) begin
            bad++; $display("FAIL issue_zero got cnt=%0d busy=%b exp cnt=2 busy=10", busy_cnt, rd_busy);
        end
        set_rd(3, 4);
        txn(1'b1, 3, 64'h3333, 1'b0, 0);
        total++;
        if (busy_cnt !== 6'd1 || rd_busy !== 2'b10 || rd_data[63:0] !== 64'h3333) begin
            bad++; $display("FAIL writeback_r3 got cnt=%0d busy=%b data=%h exp cnt=1 busy=10 data=3333",
                            busy_cnt, rd_busy, rd_data[63:0]);
        end
    endtask

    task automatic test_collision();
        set_rd(7, 10);
        txn(1'b0, 0, 64'd0, 1'b1, 7);
        total++;
        if (busy_cnt !== 6'd2) begin
            bad++; $display("FAIL issue_r7 got cnt=%0d exp=2", busy_cnt);
        end
        txn(1'b1, 7, 64'h7777, 1'b1, 7);
        total++;
        if (rd_data[63:0] !== 64'h7777 || rd_busy[0] !== 1'b1 || busy_cnt !== 6'd2) begin
            bad++; $display("FAIL same_reg got data=%h busy=%b cnt=%0d exp data=7777 busy=1 cnt=2",
                            rd_data[63:0], rd_busy[0], busy_cnt);
        end
        // Set r10 while clearing busy r4: count unchanged.
        txn(1'b1, 4, 64'h4444, 1'b1, 10);
        total++;
        if (busy_cnt !== 6'd2 || rd_busy[1] !== 1'b1) begin
            bad++; $display("FAIL set_clear_diff got cnt=%0d busy10=%b exp cnt=2 busy10=1", busy_cnt, rd_busy[1]);
        end
        // Clear of a register that is not busy.
        txn(1'b1, 20, 64'h2020, 1'b0, 0);
        total++;
        if (busy_cnt !== 6'd2) begin
            bad++; $display("FAIL clear_idle got cnt=%0d exp=2", busy_cnt);
        end
        // Re-issue to an already busy register (WAW).
        txn(1'b0, 0, 64'd0, 1'b1, 7);
        total++;
        if (busy_cnt !== 6'd2 || rd_busy[0] !== 1'b1) begin
            bad++; $display("FAIL waw_issue got cnt=%0d busy=%b exp cnt=2 busy=1", busy_cnt, rd_busy[0]);
        end
        // Set of an idle register together with clear of another idle register.
        set_rd(11, 12);
        txn(1'b1, 12, 64'h1212, 1'b1, 11);
        total++;
        if (busy_cnt !== 6'd3 || rd_busy !== 2'b01 || rd_data[127:64] !== 64'h1212) begin
            bad++; $display("FAIL set_idle_clear_idle got cnt=%0d busy=%b data=%h exp cnt=3 busy=01 data=1212",
                            busy_cnt, rd_busy, rd_data[127:64]);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] exp_data;
        logic        exp_busy;
        logic [31:0] exp_mask;
        set_rd(9, 9);
        txn(1'b0, 0, 64'd0, 1'b1, 9);
        total++;
        if (busy_cnt !== 6'd4 || rd_busy !== 2'b11 || rd_data[63:0] !== 64'h1009) begin
            bad++; $display("FAIL issue_r9 got cnt=%0d busy=%b data=%h exp cnt=4 busy=11 data=1009",
                            busy_cnt, rd_busy, rd_data[63:0]);
        end
        // Writeback to r9 observed in the same cycle, before the edge.
        wr_en   = 1'b1;
        wr_addr = 5'd9;
        wr_data = 64'hABCD;
        $display("txn wr_en=1 wr_addr=9 wr_data=%h iss_en=0 (same-cycle read)", wr_data);
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_data = 64'hABCD;
        exp_busy = 1'b0;
`else
        exp_data = 64'h1009;
        exp_busy = 1'b1;
`endif
        total++;
        if (rd_data[63:0] !== exp_data || rd_data[127:64] !== exp_data || rd_busy !== {2{exp_busy}}) begin
            bad++; $display("FAIL bypass_same_cycle got data=%h/%h busy=%b exp data=%h busy=%b",
                            rd_data[63:0], rd_data[127:64], rd_busy, exp_data, {2{exp_busy}});
        end
        cyc();
        wr_en = 1'b0;
        #1;
        total++;
        if (rd_data[63:0] !== 64'hABCD || rd_busy !== 2'b00 || busy_cnt !== 6'd3) begin
            bad++; $display("FAIL bypass_next_cycle got data=%h busy=%b cnt=%0d exp data=abcd busy=00 cnt=3",
                            rd_data[63:0], rd_busy, busy_cnt);
        end
        // Write and issue to the idle r9 together: busy must not read set before the edge.
        wr_en    = 1'b1;
        wr_addr  = 5'd9;
        wr_data  = 64'h5555;
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        $display("txn wr_en=1 wr_addr=9 wr_data=%h iss_en=1 iss_addr=9 (same-cycle read)", wr_data);
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_data = 64'h5555;
`else
        exp_data = 64'hABCD;
`endif
        total++;
        if (rd_data[63:0] !== exp_data || rd_busy[0] !== 1'b0) begin
            bad++; $display("FAIL bypass_with_issue got data=%h busy=%b exp data=%h busy=0",
                            rd_data[63:0], rd_busy[0], exp_data);
        end
        cyc();
        wr_en  = 1'b0;
        iss_en = 1'b0;
        #1;
        exp_mask = 32'h0000_0E80;   // r7, r9, r10, r11
        total++;
        if (int'(busy_cnt) != popcount(exp_mask) || rd_busy[0] !== 1'b1 || rd_data[63:0] !== 64'h5555) begin
            bad++; $display("FAIL after_collision_r9 got cnt=%0d busy=%b data=%h exp cnt=%0d busy=1 data=5555",
                            busy_cnt, rd_busy[0], rd_data[63:0], popcount(exp_mask));
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        rd_addr  = '0;
        test_reset();
        test_write_read_all();
        test_scoreboard();
        test_collision();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
